// File: rtl/fetch_unit.sv
// Instruction fetch address generator.
// Walks a program from address 0 to LAST_ADDR and accepts jump and branch
// redirects. It parks in HALT at the end of the program, or when a redirect
// points past LAST_ADDR. Only reset leaves HALT.
//
// Control input semantics (no handshake; every input is sampled at each rising edge):
//   start is a level and matters only in IDLE.
//   In RUN, the inputs are prioritised as jump > branch_taken > stall > increment.
//   A redirect therefore wins over a stall that arrives in the same cycle.
//   redirect is a registered pulse. It is high for exactly the cycle after a
//   redirect edge that was accepted.
// jump_target must be at least ADDR_W bits wide (ADDR_W <= 12).
module fetch_unit #(
  parameter int ADDR_W    = 4,
  parameter int LAST_ADDR = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [5:0]        branch_offset,
  input  logic              jump,
  input  logic [11:0]       jump_target,
  output logic [ADDR_W-1:0] address,
  output logic              fetch_valid,
  output logic              redirect,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // The offset is sign-extended to at least its own width before it is truncated to
  // the address width. This keeps the branch arithmetic modulo 2^ADDR_W for
  // any ADDR_W.
  localparam int EXT_W = (ADDR_W > 6) ? ADDR_W : 6;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_redirect;
  logic              w_redirect_nxt;

  logic [ADDR_W-1:0] w_jump_tgt;
  logic [ADDR_W-1:0] w_branch_tgt;
  logic [ADDR_W-1:0] w_redir_tgt;
  logic              w_redir_req;
  logic              w_unused_jt_hi;

  // The upper jump_target bits are ignored. They are not part of the program space.
  assign w_unused_jt_hi = ^jump_target[11:ADDR_W];
  assign w_jump_tgt     = jump_target[ADDR_W-1:0];
  assign w_branch_tgt   = r_addr + ADDR_W'(1)
                        + ADDR_W'(EXT_W'($signed(branch_offset)));
  assign w_redir_req    = jump | branch_taken;
  assign w_redir_tgt    = jump ? w_jump_tgt : w_branch_tgt;

  // State, address and redirect pulse registers; reset is asynchronous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_redirect <= w_redirect_nxt;
    end
  end

  // Next-state and next-address selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_redirect_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The first fetch is address 0, which the register already holds.
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_redir_req) begin
          // An out-of-range target stops the program where it stands.
          if (w_redir_tgt > LAST) begin
            w_state_nxt = S_HALT;
          end else begin
            w_addr_nxt     = w_redir_tgt;
            w_redirect_nxt = 1'b1;
          end
        end else if (stall) begin
          w_addr_nxt = r_addr;
        end else if (r_addr == LAST) begin
          w_state_nxt = S_HALT;
        end else begin
          w_addr_nxt = r_addr + ADDR_W'(1);
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
      end
    endcase
  end

  assign address     = r_addr;
  assign fetch_valid = (r_state == S_RUN);
  assign done        = (r_state == S_HALT);
  assign redirect    = r_redirect;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with the default parameters (ADDR_W=4, LAST_ADDR=8).
// It runs a directed vector table, hand-written multi-cycle sequences, and
// randomized cycles that are checked against a behavioural model.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_offset;
  logic        jump;
  logic [11:0] jump_target;
  logic [3:0]  address;
  logic        fetch_valid;
  logic        redirect;
  logic        done;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected outputs are packed as {address[3:0], fetch_valid, redirect, done}.
  logic [6:0] exp_q[$];

  // Behavioural model state.
  int m_addr;
  bit m_run;
  bit m_halt;
  bit m_red;

  typedef struct {
    logic        st;
    logic        sl;
    logic        br;
    logic [5:0]  off;
    logic        jp;
    logic [11:0] jt;
    int          e_addr;
    logic        e_fv;
    logic        e_red;
    logic        e_done;
  } vec_t;

  vec_t vecs[12];

  fetch_unit #(.ADDR_W(4), .LAST_ADDR(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .address      (address),
    .fetch_valid  (fetch_valid),
    .redirect     (redirect),
    .done         (done),
    .o_dbg_state  (dbg_state)
  );

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] pk(input int a, input logic fv, input logic rd, input logic dn);
    logic [3:0] a4;
    a4 = a[3:0];
    return {a4, fv, rd, dn};
  endfunction

  function automatic logic [6:0] outs();
    return {address, fetch_valid, redirect, done};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got addr=%0d fv=%b red=%b done=%b, expected addr=%0d fv=%b red=%b done=%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic st, input logic sl, input logic br, input logic [5:0] off,
                       input logic jp, input logic [11:0] jt);
    start         = st;
    stall         = sl;
    branch_taken  = br;
    branch_offset = off;
    jump          = jp;
    jump_target   = jt;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset is asserted between edges. The outputs must clear before the next clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("async_reset", outs(), pk(0, 1'b0, 1'b0, 1'b0));
    #1 reset = 1'b0;
    m_addr = 0;
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_red  = 1'b0;
  endtask

  // Reference model: applies the fetch rules with integer arithmetic modulo 16.
  task automatic model_step(input logic st, input logic sl, input logic br, input logic [5:0] off,
                            input logic jp, input logic [11:0] jt);
    int t;
    int so;
    t = 0;
    so = $signed(off);
    m_red = 1'b0;
    if (m_halt) begin
      // frozen until reset
    end else if (!m_run) begin
      if (st) m_run = 1'b1;
    end else begin
      if (jp) t = int'(jt) % 16;
      else if (br) t = (((m_addr + 1 + so) % 16) + 16) % 16;
      if (jp || br) begin
        if (t > 8) begin
          m_run  = 1'b0;
          m_halt = 1'b1;
        end else begin
          m_addr = t;
          m_red  = 1'b1;
        end
      end else if (sl) begin
        // hold
      end else if (m_addr == 8) begin
        m_run  = 1'b0;
        m_halt = 1'b1;
      end else begin
        m_addr = m_addr + 1;
      end
    end
    exp_q.push_back(pk(m_addr, m_run, m_red, m_halt));
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    logic [6:0] exp_v;
    logic st, sl, br, jp;
    logic [5:0] off;
    logic [11:0] jt;

    reset = 1'b1;
    idle_inputs();
    #3 reset = 1'b0;

    // Vector table, applied in sequence from reset.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 12'd0,   0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 12'd0,   1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 12'd0,   2, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 12'd0,   3, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 6'h3E, 1'b0, 12'd0,   2, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 12'h007, 7, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 12'd0,   7, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 12'd0,   8, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 12'd0,   8, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 6'd5,  1'b0, 12'd0,   8, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 12'h003, 8, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 12'd0,   8, 1'b0, 1'b0, 1'b1};

    do_reset();
    tick();
    check("idle_after_reset", outs(), pk(0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].off, vecs[i].jp, vecs[i].jt);
      tick();
      check($sformatf("vec%0d", i), outs(), pk(vecs[i].e_addr, vecs[i].e_fv, vecs[i].e_red, vecs[i].e_done));
    end

    // Free run from start to HALT.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
    for (int i = 0; i <= 8; i++) begin
      tick();
      check($sformatf("freerun_%0d", i), outs(), pk(i, 1'b1, 1'b0, 1'b0));
    end
    tick();
    check("freerun_halt", outs(), pk(8, 1'b0, 1'b0, 1'b1));
    tick();
    check("freerun_halt_hold", outs(), pk(8, 1'b0, 1'b0, 1'b1));

    // Three-cycle stall at address 5, then an asynchronous reset at address 6.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
    tick();
    run_steps(5);
    check("reach5", outs(), pk(5, 1'b1, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 12'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall5_%0d", i), outs(), pk(5, 1'b1, 1'b0, 1'b0));
    end
    idle_inputs();
    tick();
    check("after_stall", outs(), pk(6, 1'b1, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 12'd0);
    do_reset();
    idle_inputs();
    run_steps(2);
    check("no_start_stays_idle", outs(), pk(0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
    tick();
    check("restart", outs(), pk(0, 1'b1, 1'b0, 1'b0));

    // A jump to an out-of-range target at address 4 halts in place.
    run_steps(4);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 12'h00C);
    tick();
    check("jump_oob_halt", outs(), pk(4, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 12'h002);
    tick();
    check("halt_ignores", outs(), pk(4, 1'b0, 1'b0, 1'b1));

    // A branch that wraps below address 0 reaches 15, which is out of range.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 6'h3E, 1'b0, 12'd0);
    tick();
    check("branch_wrap_halt", outs(), pk(0, 1'b0, 1'b0, 1'b1));

    // Only the low ADDR_W bits of the jump target are used.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 12'hFF3);
    tick();
    check("jump_trunc", outs(), pk(3, 1'b1, 1'b1, 1'b0));
    idle_inputs();
    tick();
    check("redirect_pulse_end", outs(), pk(4, 1'b1, 1'b0, 1'b0));

    // Randomized cycles checked against the model through the expected queue.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
        do_reset();
      end
      st  = ($urandom_range(0, 2) == 0);
      sl  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      off = 6'($urandom_range(0, 63));
      jp  = ($urandom_range(0, 9) == 0);
      jt  = 12'($urandom_range(0, 4095));
      drive(st, sl, br, off, jp, jt);
      model_step(st, sl, br, off, jp, jt);
      tick();
      exp_v = exp_q.pop_front();
      check($sformatf("rand%0d", c), outs(), exp_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, width of the instruction-memory address.
REQ-002 SHALL provide parameter LAST_ADDR, default 8, highest valid program address.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; begins fetching from address 0 when in IDLE.
REQ-006 SHALL have port stall  input  1  hold current address for this cycle.
REQ-007 SHALL have port branch_taken  input  1  redirect to PC-relative target this cycle.
REQ-008 SHALL have port branch_offset  input  6  signed word offset (I-type immediate field [5:0]).
REQ-009 SHALL have port jump  input  1  redirect to absolute target this cycle.
REQ-010 SHALL have port jump_target  input  12  J-type address field [11:0].
REQ-011 SHALL have port address  output  ADDR_W  registered fetch address driven to instruction memory.
REQ-012 SHALL have port fetch_valid  output  1  high while address is a live fetch (RUN state).
REQ-013 SHALL have port redirect  output  1  one-cycle pulse after a taken jump/branch; downstream flushes.
REQ-014 SHALL have port done  output  1  high in HALT state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALT.
REQ-016 IDLE: address held 0, fetch_valid=0; start=1 -> RUN on next edge, address stays 0.
REQ-017 RUN: fetch_valid=1; next address chosen by priority jump > branch_taken > stall > increment.
REQ-018 Jump: next address = jump_target[ADDR_W-1:0]; upper bits ignored.
REQ-019 Branch: next address = (address + 1 + sign_extend(branch_offset)) modulo 2^ADDR_W.
REQ-020 Stall (no redirect): address unchanged, remain RUN, redirect=0.
REQ-021 Increment: next address = address + 1.
REQ-022 Redirect (jump or branch) SHALL override stall in the same cycle.
REQ-023 redirect SHALL be high exactly the cycle after a taken jump/branch edge, else 0.
REQ-024 Increment from address == LAST_ADDR SHALL enter HALT, address held at LAST_ADDR.
REQ-025 Redirect target > LAST_ADDR (unsigned, after truncation) SHALL enter HALT, address held at its pre-redirect value, redirect=0.
REQ-026 Stall at address == LAST_ADDR SHALL hold RUN (no halt while stalled).
REQ-027 HALT: done=1, fetch_valid=0, address frozen; all inputs except reset ignored; exit only by reset.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 Branch wrap-around (e.g. address 0, offset -2) SHALL truncate to 4'b1111, then REQ-025 applies.

Reset
REQ-030 reset=1 SHALL immediately, without clock, force IDLE, address=0, fetch_valid=0, redirect=0, done=0.
REQ-031 reset asserted mid-RUN or in HALT SHALL discard pending redirect/stall; fetching resumes only after deassert and start.
REQ-032 Outputs SHALL take no X after reset for any parameter values.

Verification
REQ-033 reset, start=1, no other inputs for 10 cycles -> address 0,1,...,8 then done=1, address=8, fetch_valid=0.
REQ-034 RUN at address 3, branch_taken=1, offset=6'b111110 (-2) -> next address 2, redirect=1 for one cycle.
REQ-035 RUN at address 2, jump=1, jump_target=12'h007, stall=1 same cycle -> next address 7, redirect=1.
REQ-036 RUN at address 5, stall=1 for 3 cycles -> address 5 held 3 cycles, then 6; redirect stays 0.
REQ-037 RUN at address 4, jump_target=12'h00C -> HALT, address 4, done=1; subsequent start/jump ignored.
REQ-038 reset pulsed asynchronously between edges while address=6 -> address=0, fetch_valid=0 immediately; start needed to resume.
